scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4, SHALL set the width of the dwell input.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL be the level-sampled request to begin scanning.
REQ-005 stop  input  1  SHALL be the level-sampled request to end scanning.
REQ-006 dwell  input  DWELL_W  SHALL give the cycles each channel is driven; 0 SHALL be treated as 1.
REQ-007 mask  input  4  SHALL mark channels to skip when the bit is 1 (bit n = channel n).
REQ-008 i0  output  1  SHALL be the select MSB for the downstream 2-to-4 decoder.
REQ-009 i1  output  1  SHALL be the select LSB; channel index = {i0,i1}.
REQ-010 en  output  1  SHALL be the decoder enable.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 wrap  output  1  SHALL pulse for one cycle when the scan advances from the highest to the lowest unmasked channel.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 FSM states SHALL be IDLE, BLANK and DRIVE.
REQ-015 IDLE: en=0, busy=0; start=1, stop=0 and mask!=4'b1111 -> BLANK, with {i0,i1} loaded with the lowest unmasked channel.
REQ-016 IDLE with mask==4'b1111 SHALL ignore start and remain in IDLE.
REQ-017 BLANK SHALL last exactly one cycle with en=0 (break-before-make), then go to DRIVE.
REQ-018 DRIVE: en=1 for exactly max(dwell,1) cycles; dwell SHALL be sampled on DRIVE entry.
REQ-019 End of DRIVE: {i0,i1} -> next unmasked channel in ascending order, wrapping 3->0; state -> BLANK.
REQ-020 mask SHALL be sampled only at channel advance; a change mid-DRIVE SHALL not affect the current channel.
REQ-021 If only one channel is unmasked, the scan SHALL alternate BLANK/DRIVE on that channel and assert wrap at each advance.
REQ-022 If mask becomes 4'b1111 at an advance, the FSM SHALL go to IDLE with en=0.
REQ-023 stop=1 in BLANK or DRIVE SHALL force en=0 and state IDLE on the next cycle, aborting the dwell.
REQ-024 start and stop both high in IDLE: stop SHALL win; start while busy SHALL be ignored.
REQ-025 wrap SHALL coincide with the cycle {i0,i1} takes the wrapped value; it SHALL be 0 otherwise.
REQ-026 Latency: start sampled at edge t -> BLANK at t+1 -> en=1 from t+2.

Reset
REQ-027 rst=1 SHALL set state IDLE, i0=0, i1=0, en=0, busy=0, wrap=0 and clear the dwell counter on the next edge.
REQ-028 rst SHALL take priority over start and stop, including mid-DRIVE.

Structure
REQ-029 The FSM state encoding and the channel count (4) SHALL live in a shared package, scan_pkg.
REQ-030 The next-unmasked-channel search SHALL be one combinational sub-module, next_chan (inputs: current index, mask; outputs: next index, wrap flag).
REQ-031 i0, i1 and en SHALL connect directly to a decoder2to4_gl instance in the bench.

Verification
REQ-032 mask=0000, dwell=2, start pulse -> en pattern 0,1,1,0,1,1,... on channels 0,1,2,3; wrap pulses on the 3->0 advance.
REQ-033 mask=1010, dwell=1 -> only channels 0 and 2 driven, each for 1 cycle, each preceded by 1 blank cycle.
REQ-034 dwell=0 -> behaves identically to dwell=1.
REQ-035 stop asserted in the 2nd cycle of DRIVE, dwell=5 -> en=0 and busy=0 on the next cycle.
REQ-036 mask=1111 with start held high -> busy stays 0 and en stays 0.
REQ-037 rst in the middle of DRIVE on channel 2 -> next cycle i0=0, i1=0, en=0, busy=0; decoder outputs all 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizing for the channel scanner.
//   state_t  : scanner FSM states
//   NUM_CHAN : number of decoder channels scanned
//   CHAN_W   : width of a channel index
package scan_pkg;

  localparam int unsigned NUM_CHAN = 4;
  localparam int unsigned CHAN_W   = $clog2(NUM_CHAN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage : scan_pkg

// File: rtl/decoder2to4_gl.sv
// Gate-level 2-to-4 decoder with enable, driven by the scanner.
//   i0 : select MSB, i1 : select LSB, en : enable
//   y  : one-hot output, y[{i0,i1}] = en
module decoder2to4_gl (
  input  logic       i0,
  input  logic       i1,
  input  logic       en,
  output logic [3:0] y
);

  wire i0_n;
  wire i1_n;
  wire y0;
  wire y1;
  wire y2;
  wire y3;

  not g_n0 (i0_n, i0);
  not g_n1 (i1_n, i1);
  and g_y0 (y0, en, i0_n, i1_n);
  and g_y1 (y1, en, i0_n, i1);
  and g_y2 (y2, en, i0,   i1_n);
  and g_y3 (y3, en, i0,   i1);

  assign y = {y3, y2, y1, y0};

endmodule : decoder2to4_gl

// File: rtl/next_chan.sv
// Next-unmasked-channel search (combinational).
//   cur    : current channel index
//   mask   : 1 = skip that channel
//   nxt_c  : next unmasked channel in ascending order, wrapping; cur if none
//   wrap_c : the step wrapped (next index not above cur, incl. single channel)
module next_chan
  import scan_pkg::*;
(
  input  logic [CHAN_W-1:0]   cur,
  input  logic [NUM_CHAN-1:0] mask,
  output logic [CHAN_W-1:0]   nxt_c,
  output logic                wrap_c
);

  logic              found;
  logic [CHAN_W-1:0] cand;

  // Probe cur+1 .. cur+NUM_CHAN; the last probe is cur itself, so a lone
  // unmasked channel selects itself.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    nxt_c = cur;
    for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
      cand = cur + CHAN_W'(k);
      if (!found && !mask[cand]) begin
        found = 1'b1;
        nxt_c = cand;
      end
    end
    wrap_c = found && (nxt_c <= cur);
  end

endmodule : next_chan

// File: rtl/scan_ctrl.sv
// Round-robin channel scanner with break-before-make blanking.
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : level requests to begin / end scanning (stop wins)
//   dwell        : drive cycles per channel (0 acts as 1), sampled on DRIVE entry
//   mask         : 1 = skip channel, sampled at each channel advance
//   i0, i1       : registered channel select {i0,i1}
//   en           : registered decoder enable (high only in DRIVE)
//   busy         : registered, high when not IDLE
//   wrap         : registered one-cycle pulse when the index wraps
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic               i0,
  output logic               i1,
  output logic               en,
  output logic               busy,
  output logic               wrap
);

  state_t             state_q;
  state_t             state_d;
  logic [CHAN_W-1:0]  chan_q;
  logic [CHAN_W-1:0]  chan_d;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic               en_d;
  logic               busy_d;
  logic               wrap_d;

  logic [CHAN_W-1:0]  search_from;
  logic [CHAN_W-1:0]  nxt_chan;
  logic               nxt_wrap;
  logic               all_masked;

  assign all_masked = &mask;

  // From IDLE, searching after the top channel yields the lowest unmasked one.
  assign search_from = (state_q == IDLE) ? CHAN_W'(NUM_CHAN - 1) : chan_q;

  next_chan u_next_chan (
    .cur    (search_from),
    .mask   (mask),
    .nxt_c  (nxt_chan),
    .wrap_c (nxt_wrap)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && !all_masked) begin
          state_d = BLANK;
          chan_d  = nxt_chan;
        end
      end

      BLANK: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          state_d = DRIVE;
          // cnt holds remaining DRIVE cycles minus one
          cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end
      end

      DRIVE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (all_masked) begin
          state_d = IDLE;
        end else begin
          state_d = BLANK;
          chan_d  = nxt_chan;
          wrap_d  = nxt_wrap;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      cnt_d = '0;
    end

    en_d   = (state_d == DRIVE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      chan_q  <= '0;
      cnt_q   <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      en      <= en_d;
      busy    <= busy_d;
      wrap    <= wrap_d;
    end
  end

  assign i0 = chan_q[1];
  assign i1 = chan_q[0];

endmodule : scan_ctrl

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl driving a decoder2to4_gl.
module tb_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] dwell;
  logic [3:0] mask;
  logic       i0;
  logic       i1;
  logic       en;
  logic       busy;
  logic       wrap;
  logic [3:0] y;

  int checks   = 0;
  int failures = 0;

  scan_ctrl #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .dwell (dwell),
    .mask  (mask),
    .i0    (i0),
    .i1    (i1),
    .en    (en),
    .busy  (busy),
    .wrap  (wrap)
  );

  decoder2to4_gl u_dec (
    .i0 (i0),
    .i1 (i1),
    .en (en),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] dwell;
    logic [3:0] mask;
    logic [1:0] ch;
    logic       en;
    logic       busy;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic s, input logic p,
                     input logic [3:0] d, input logic [3:0] m,
                     input logic [1:0] ch, input logic e, input logic b, input logic w);
    vec_t v;
    v.name = name; v.rst = r; v.start = s; v.stop = p; v.dwell = d; v.mask = m;
    v.ch = ch; v.en = e; v.busy = b; v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [3:0] exp_y;
    rst = v.rst; start = v.start; stop = v.stop; dwell = v.dwell; mask = v.mask;
    @(posedge clk);
    #1;
    exp_y = 4'b0000;
    if (v.en) exp_y[v.ch] = 1'b1;
    check(v.name, {20'd0, i0, i1, en, busy, wrap, 3'd0, y},
                  {20'd0, v.ch, v.en, v.busy, v.wrap, 3'd0, exp_y});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int wraps;
    int wrap_bad;

    rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 4'd0; mask = 4'd0;

    // Full scan, dwell 2, all channels
    add("a_rst",   1,0,0, 2,4'b0000, 0,0,0,0);
    add("a_start", 0,1,0, 2,4'b0000, 0,0,1,0);
    add("a_d0a",   0,0,0, 2,4'b0000, 0,1,1,0);
    add("a_d0b",   0,0,0, 2,4'b0000, 0,1,1,0);
    add("a_b1",    0,0,0, 2,4'b0000, 1,0,1,0);
    add("a_d1a",   0,0,0, 2,4'b0000, 1,1,1,0);
    add("a_d1b",   0,0,0, 2,4'b0000, 1,1,1,0);
    add("a_b2",    0,0,0, 2,4'b0000, 2,0,1,0);
    add("a_d2a",   0,0,0, 2,4'b0000, 2,1,1,0);
    add("a_d2b",   0,0,0, 2,4'b0000, 2,1,1,0);
    add("a_b3",    0,0,0, 2,4'b0000, 3,0,1,0);
    add("a_d3a",   0,0,0, 2,4'b0000, 3,1,1,0);
    add("a_d3b",   0,0,0, 2,4'b0000, 3,1,1,0);
    add("a_b0w",   0,0,0, 2,4'b0000, 0,0,1,1);
    add("a_d0c",   0,0,0, 2,4'b0000, 0,1,1,0);
    add("a_d0d",   0,0,0, 2,4'b0000, 0,1,1,0);
    add("a_b1b",   0,0,0, 2,4'b0000, 1,0,1,0);
    add("a_stopb", 0,0,1, 2,4'b0000, 1,0,0,0);
    add("a_stwin", 0,1,1, 2,4'b0000, 1,0,0,0);
    // Mask 1010, dwell 1: channels 0 and 2 only
    add("b_rst",   1,0,0, 1,4'b1010, 0,0,0,0);
    add("b_start", 0,1,0, 1,4'b1010, 0,0,1,0);
    add("b_d0",    0,0,0, 1,4'b1010, 0,1,1,0);
    add("b_b2",    0,0,0, 1,4'b1010, 2,0,1,0);
    add("b_d2",    0,0,0, 1,4'b1010, 2,1,1,0);
    add("b_b0w",   0,0,0, 1,4'b1010, 0,0,1,1);
    add("b_d0b",   0,0,0, 1,4'b1010, 0,1,1,0);
    add("b_b2b",   0,0,0, 1,4'b1010, 2,0,1,0);
    // Dwell 0 acts as 1; start held while busy; rst beats start
    add("c_rst",   1,1,0, 0,4'b0000, 0,0,0,0);
    add("c_start", 0,1,0, 0,4'b0000, 0,0,1,0);
    add("c_d0",    0,1,0, 0,4'b0000, 0,1,1,0);
    add("c_b1",    0,1,0, 0,4'b0000, 1,0,1,0);
    add("c_d1",    0,1,0, 0,4'b0000, 1,1,1,0);
    add("c_b2",    0,1,0, 0,4'b0000, 2,0,1,0);
    // Stop in second DRIVE cycle, dwell 5
    add("d_rst",   1,0,0, 5,4'b0000, 0,0,0,0);
    add("d_start", 0,1,0, 5,4'b0000, 0,0,1,0);
    add("d_dr1",   0,0,0, 5,4'b0000, 0,1,1,0);
    add("d_dr2",   0,0,0, 5,4'b0000, 0,1,1,0);
    add("d_stop",  0,0,1, 5,4'b0000, 0,0,0,0);
    // All masked: start ignored
    add("e_rst",   1,0,0, 1,4'b1111, 0,0,0,0);
    add("e_hold1", 0,1,0, 1,4'b1111, 0,0,0,0);
    add("e_hold2", 0,1,0, 1,4'b1111, 0,0,0,0);
    add("e_hold3", 0,1,0, 1,4'b1111, 0,0,0,0);
    // Reset mid-DRIVE on channel 2
    add("f_rst",   1,0,0, 3,4'b0011, 0,0,0,0);
    add("f_start", 0,1,0, 3,4'b0011, 2,0,1,0);
    add("f_d2a",   0,0,0, 3,4'b0011, 2,1,1,0);
    add("f_d2b",   0,0,0, 3,4'b0011, 2,1,1,0);
    add("f_midrst",1,1,0, 3,4'b0011, 0,0,0,0);
    // Single channel wraps every advance; all-masked at advance -> IDLE
    add("g_rst",   1,0,0, 1,4'b1011, 0,0,0,0);
    add("g_start", 0,1,0, 1,4'b1011, 2,0,1,0);
    add("g_d1",    0,0,0, 1,4'b1011, 2,1,1,0);
    add("g_b1w",   0,0,0, 1,4'b1011, 2,0,1,1);
    add("g_d2",    0,0,0, 1,4'b1011, 2,1,1,0);
    add("g_b2w",   0,0,0, 1,4'b1011, 2,0,1,1);
    add("g_d3",    0,0,0, 1,4'b1011, 2,1,1,0);
    add("g_allm",  0,0,0, 1,4'b1111, 2,0,0,0);
    // Mask change mid-DRIVE keeps current channel
    add("h_rst",   1,0,0, 3,4'b0000, 0,0,0,0);
    add("h_start", 0,1,0, 3,4'b0000, 0,0,1,0);
    add("h_d0a",   0,0,0, 3,4'b0000, 0,1,1,0);
    add("h_d0b",   0,0,0, 3,4'b0011, 0,1,1,0);
    add("h_d0c",   0,0,0, 3,4'b0011, 0,1,1,0);
    add("h_b2",    0,0,0, 3,4'b0011, 2,0,1,0);

    foreach (vecs[i]) apply(vecs[i]);

    // Start-to-enable latency
    rst = 1'b1; start = 1'b0; stop = 1'b0; dwell = 4'd1; mask = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("lat_blank", {30'd0, busy, en}, {30'd0, 2'b10});
    start = 1'b0;
    waited = 0;
    while (!en && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    check("lat_en", 32'(waited), 32'd1);

    // Two full dwell-1 rotations: exactly two wraps, each on channel 0
    wraps = 0;
    wrap_bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (wrap) begin
        wraps++;
        if ({i0, i1} != 2'd0) wrap_bad++;
      end
    end
    check("wrap_count", 32'(wraps), 32'd2);
    check("wrap_chan", 32'(wrap_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scan_ctrl
